serial_mag_compare_ctrl: RTL and testbench
==========================================

# serial_mag_compare_ctrl

Sequencer that performs an N-bit unsigned magnitude comparison by stepping a single 1-bit compare stage from MSB to LSB, one bit per clock. It stops at the first differing bit and reports one-hot equal/greater/lesser flags with a start/busy/done handshake. It sits between a requester that holds two operands and the 1-bit comparator datapath, so wide comparisons reuse one bit cell instead of a full-width comparator.

## Interface
- WIDTH, 8: operand width in bits; legal range ≥ 1.
- IDXW, $clog2(WIDTH) (minimum 1): width of the bit index.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request; accepted only when busy = 0.
- a  input  WIDTH  operand A, unsigned; sampled only on the acceptance edge.
- b  input  WIDTH  operand B, unsigned; sampled only on the acceptance edge.
- busy  output  1  high in COMPARE and DONE.
- done  output  1  one-cycle pulse, high in DONE.
- equal  output  1  result: A == B.
- greater  output  1  result: A > B.
- lesser  output  1  result: A < B.
- bit_idx  output  IDXW  index of the bit under compare; meaningful in COMPARE only.

## Operation
- States: IDLE, COMPARE, DONE.
- IDLE:
  - If start = 1: latch a and b into internal registers, set bit_idx = WIDTH-1, go to COMPARE.
  - Otherwise stay in IDLE.
- COMPARE: evaluate latched a[bit_idx] against b[bit_idx].
  - Bits differ (a = 1, b = 0): set greater = 1, clear equal and lesser, go to DONE.
  - Bits differ (a = 0, b = 1): set lesser = 1, clear equal and greater, go to DONE.
  - Bits equal, bit_idx = 0: set equal = 1, clear greater and lesser, go to DONE.
  - Bits equal, bit_idx > 0: decrement bit_idx, stay in COMPARE.
- DONE: done = 1 for exactly one cycle, then go to IDLE unconditionally.
- Result flags:
  - Updated only on the edge that enters DONE; held until the next completion.
  - After the first completion, exactly one flag is high.
- Requests:
  - start is ignored in COMPARE and DONE. No queuing.
  - Input operand changes after acceptance have no effect.
- WIDTH = 1: a single COMPARE cycle always exits to DONE.

## Timing
- Reset:
  - state = IDLE, busy = 0, done = 0, equal = greater = lesser = 0, bit_idx = 0.
  - Internal operand registers are cleared to 0.
- Reset asserted mid-operation: on that edge, the block returns to IDLE and all reset values apply. No done pulse is issued and the partial result is discarded.
- Latency: start is accepted on edge E0.
  - First differing bit at index i: COMPARE lasts WIDTH-i cycles, and done is high in the cycle after edge E0 + (WIDTH-i).
  - Equal operands: COMPARE lasts WIDTH cycles, and done is high after edge E0 + WIDTH.
- busy:
  - Rises in the cycle after acceptance.
  - Falls in the cycle after done.
  - Minimum start-to-start spacing is therefore (compare cycles + 2).
- start held high continuously: a new request is accepted in the first IDLE cycle after DONE, using the a and b values present at that edge.

## Test plan
- Equal operands: reset, then start with a = 0x5A, b = 0x5A. Require 8 COMPARE cycles, done high after edge E0 + 8, equal = 1, greater = lesser = 0, busy low in the cycle after done.
- MSB decides: start with a = 0x80, b = 0x7F. Require greater = 1 and done after edge E0 + 1, i.e. one COMPARE cycle with bit_idx = 7.
- LSB decides: start with a = 0x12, b = 0x13. Require lesser = 1, done after edge E0 + 8, and bit_idx stepping 7 down to 0.
- Busy lockout: start with a = 0x40, b = 0x00, then pulse start with a = 0x00, b = 0xFF while busy. Require greater = 1 from the first request only, and no second done pulse.
- Reset mid-compare: start with a = 0x01, b = 0x00 (outcome is greater), then drop rst_n for one cycle on the 4th COMPARE cycle. Require no done pulse, all outputs 0 on the following cycle, and state IDLE.
- Back-to-back with start held high: first request a = 0x00, b = 0x01 gives lesser; second request a = 0xFF, b = 0xFF is accepted in the first IDLE cycle. Require lesser, then equal, with the flags switching on the edge that enters the second DONE.

Source files
------------

// File: rtl/serial_mag_compare_ctrl_if.sv
// rtl/serial_mag_compare_ctrl_if.sv - request/result bundle between requester and the serial comparator
interface serial_mag_compare_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             equal;
    logic             greater;
    logic             lesser;
    logic [IDXW-1:0]  bit_idx;

    modport master (
        output start, a, b,
        input  busy, done, equal, greater, lesser, bit_idx
    );

    modport slave (
        input  start, a, b,
        output busy, done, equal, greater, lesser, bit_idx
    );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// rtl/serial_mag_compare_ctrl.sv - MSB-first bit-serial unsigned magnitude compare sequencer
module serial_mag_compare_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_mag_compare_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    // Shifting selects the bit under compare without width mismatch when WIDTH == 1.
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             a_bit, b_bit;

    assign a_sh  = a_q >> idx_q;
    assign b_sh  = b_q >> idx_q;
    assign a_bit = a_sh[0];
    assign b_bit = b_sh[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = IDXW'(WIDTH - 1);
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                // First differing bit from the top decides; equality needs the LSB reached.
                if (a_bit && !b_bit) begin
                    {eq_d, gt_d, lt_d} = 3'b010;
                    state_d            = S_DONE;
                end else if (!a_bit && b_bit) begin
                    {eq_d, gt_d, lt_d} = 3'b001;
                    state_d            = S_DONE;
                end else if (idx_q == '0) begin
                    {eq_d, gt_d, lt_d} = 3'b100;
                    state_d            = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.equal   = eq_q;
    assign bus.greater = gt_q;
    assign bus.lesser  = lt_q;
    assign bus.bit_idx = idx_q;
endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// tb/tb_serial_mag_compare_ctrl.sv - self-checking bench for serial_mag_compare_ctrl
module tb_serial_mag_compare_ctrl;
    localparam int W    = 8;
    localparam int IDXW = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_mag_compare_ctrl_if #(.WIDTH(W), .IDXW(IDXW)) bus ();

    serial_mag_compare_ctrl #(.WIDTH(W), .IDXW(IDXW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [IDXW-1:0] idx_log [0:31];

    function automatic logic [2:0] flags_now();
        return {bus.equal, bus.greater, bus.lesser};
    endfunction

    // Reference: scan from the top for the first differing bit; result is set by numeric order.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output int cyc, output logic [2:0] fl);
        logic [W-1:0] diff;
        diff = x ^ y;
        cyc  = W;
        fl   = 3'b100;
        for (int i = W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                cyc = W - i;
                fl  = (x > y) ? 3'b010 : 3'b001;
                break;
            end
        end
    endfunction

    // Issues one request, then observes until done (bounded); returns at the negedge of the done cycle.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         output int ncmp, output logic [2:0] fl, output bit seen);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~x;
        bus.b     = ~y;
        ncmp = 0;
        seen = 1'b0;
        fl   = 3'b000;
        for (int k = 0; k < W + 4 && !seen; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                fl   = flags_now();
            end else begin
                if (bus.busy && ncmp < 32) idx_log[ncmp] = bus.bit_idx;
                ncmp++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.equal, bus.greater, bus.lesser, bus.bit_idx} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b flags=%b idx=%0d want all 0",
                     bus.busy, bus.done, flags_now(), bus.bit_idx);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_equal();
        int n; logic [2:0] fl; bit seen;
        do_op(8'h5A, 8'h5A, n, fl, seen);
        checks++;
        if (!seen || n != 8) begin
            errors++;
            $display("FAIL equal_latency got seen=%0d cycles=%0d want 1 8", seen, n);
        end
        checks++;
        if (fl !== 3'b100) begin
            errors++;
            $display("FAIL equal_flags got %b want 100", fl);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL equal_busy_fall got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_msb();
        int n; logic [2:0] fl; bit seen;
        do_op(8'h80, 8'h7F, n, fl, seen);
        checks++;
        if (!seen || n != 1 || idx_log[0] !== 3'd7) begin
            errors++;
            $display("FAIL msb_latency got seen=%0d cycles=%0d idx=%0d want 1 1 7", seen, n, idx_log[0]);
        end
        checks++;
        if (fl !== 3'b010) begin
            errors++;
            $display("FAIL msb_flags got %b want 010", fl);
        end
    endtask

    task automatic test_lsb();
        int n; logic [2:0] fl; bit seen;
        do_op(8'h12, 8'h13, n, fl, seen);
        checks++;
        if (!seen || n != 8) begin
            errors++;
            $display("FAIL lsb_latency got seen=%0d cycles=%0d want 1 8", seen, n);
        end
        checks++;
        if (fl !== 3'b001) begin
            errors++;
            $display("FAIL lsb_flags got %b want 001", fl);
        end
        for (int k = 0; k < 8 && k < n; k++) begin
            checks++;
            if (idx_log[k] !== IDXW'(7 - k)) begin
                errors++;
                $display("FAIL lsb_bit_idx step %0d got %0d want %0d", k, idx_log[k], 7 - k);
            end
        end
    endtask

    task automatic test_lockout();
        int dones; logic [2:0] fl;
        dones = 0;
        fl    = 3'b000;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h40;
        bus.b     = 8'h00;
        @(negedge clk);
        bus.a = 8'h00;
        bus.b = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin
                dones++;
                fl        = flags_now();
                bus.start = 1'b0;
            end
            if (k == 5) bus.start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL lockout_done_count got %0d want 1", dones);
        end
        checks++;
        if (fl !== 3'b010) begin
            errors++;
            $display("FAIL lockout_flags got %b want 010", fl);
        end
    endtask

    task automatic test_reset_mid();
        int cmp; int dones;
        cmp   = 0;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.busy, bus.done, bus.equal, bus.greater, bus.lesser, bus.bit_idx} !== 8'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got busy=%b done=%b flags=%b idx=%0d want all 0",
                     bus.busy, bus.done, flags_now(), bus.bit_idx);
        end
        for (int k = 0; k < 12; k++) begin
            if (bus.done) dones++;
            if (bus.busy) cmp++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0 || cmp != 0) begin
            errors++;
            $display("FAIL reset_mid_idle got dones=%0d busy_cycles=%0d want 0 0", dones, cmp);
        end
    endtask

    task automatic test_back_to_back();
        int n; bit seen; logic [2:0] fl; bit held_ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h00;
        bus.b     = 8'h01;
        @(negedge clk);
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        seen  = 1'b0;
        for (int k = 0; k < W + 4 && !seen; k++) begin
            if (bus.done) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || flags_now() !== 3'b001) begin
            errors++;
            $display("FAIL b2b_first got seen=%0d flags=%b want 1 001", seen, flags_now());
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap got busy=%b want 0", bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        n       = 0;
        seen    = 1'b0;
        held_ok = 1'b1;
        fl      = 3'b000;
        for (int k = 0; k < W + 4 && !seen; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                fl   = flags_now();
            end else begin
                if (flags_now() !== 3'b001) held_ok = 1'b0;
                n++;
                @(negedge clk);
            end
        end
        checks++;
        if (!held_ok || n != 8) begin
            errors++;
            $display("FAIL b2b_second_compare got held=%0d cycles=%0d want 1 8", held_ok, n);
        end
        checks++;
        if (!seen || fl !== 3'b100) begin
            errors++;
            $display("FAIL b2b_second_flags got seen=%0d flags=%b want 1 100", seen, fl);
        end
    endtask

    task automatic test_random();
        int n, en; logic [2:0] fl, ef; bit seen;
        logic [W-1:0] x, y;
        for (int t = 0; t < 40; t++) begin
            x = W'($urandom);
            case ($urandom_range(0, 2))
                0:       y = x;
                1:       y = x ^ (W'(1) << $urandom_range(0, W - 1));
                default: y = W'($urandom);
            endcase
            model(x, y, en, ef);
            do_op(x, y, n, fl, seen);
            checks++;
            if (!seen || n != en || fl !== ef) begin
                errors++;
                $display("FAIL random a=%h b=%h got seen=%0d cycles=%0d flags=%b want 1 %0d %b",
                         x, y, seen, n, fl, en, ef);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_equal();
        test_msb();
        test_lsb();
        test_lockout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
